axi4lite_slave_regfile: RTL and testbench
=========================================

AXI4LITE_SLAVE_REGFILE -- requirements
Module: axi4lite_slave_regfile

Interface
REQ-001 Parameter G_AXI4_LITE_ADDR_WIDTH, default 32, is the AXI address width.
REQ-002 Parameter G_AXI4_LITE_DATA_WIDTH, default 32, is the data width; only 32 is supported.
REQ-003 Parameter G_NB_REGS, default 16, is the number of 32-bit registers; it SHALL be a power of two, 2..256.
REQ-004 Parameter G_REG0_ID, default 32'hA5A5_0001, is the read-only value of register 0.
REQ-005 clk  in  1  the single clock; all logic is on its rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 awvalid in 1, awaddr in ADDR_W, awprot in 3 (ignored), awready out 1: write address channel.
REQ-008 wvalid in 1, wdata in 32, wstrb in 4, wready out 1: write data channel.
REQ-009 bvalid out 1, bresp out 2, bready in 1: write response channel.
REQ-010 arvalid in 1, araddr in ADDR_W, arprot in 3 (ignored), arready out 1: read address channel.
REQ-011 rvalid out 1, rdata out 32, rresp out 2, rready in 1: read data channel.
REQ-012 reg_out  out  G_NB_REGS*32  flattened register contents; register i at bits [32*i+31:32*i].
REQ-013 reg_wr_pulse  out  G_NB_REGS  one-cycle strobe per register on each committed write.

Function
REQ-014 Register index SHALL be addr[log2(G_NB_REGS)+1:2]; addr[1:0] ignored; any nonzero bit above the index field marks the access out of range.
REQ-015 Write path SHALL capture AW and W independently: awready=1 while no address held and bvalid=0; wready=1 while no data held and bvalid=0.
REQ-016 AW and W SHALL be accepted in either order or in the same cycle; the held item waits for the other without limit.
REQ-017 The cycle after both are held, the write SHALL commit: per-byte update where wstrb[k]=1; bvalid=1; both holding flags clear.
REQ-018 In-range write to register 1..N-1: bresp=2'b00 (OKAY), reg_wr_pulse[i]=1 for exactly that commit cycle.
REQ-019 Write to register 0 or out of range: no register change, no pulse, bresp=2'b10 (SLVERR).
REQ-020 bvalid and bresp SHALL hold stable until bvalid&bready; bvalid deasserts the next cycle; no new AW/W is accepted while bvalid=1.
REQ-021 Read path: arready=1 whenever rvalid=0; on arvalid&arready, rvalid=1 the next cycle with rdata sampled from registers at the handshake edge.
REQ-022 Read of register 0 returns G_REG0_ID; in-range read rresp=2'b00; out-of-range read rdata=0, rresp=2'b10.
REQ-023 rvalid, rdata, rresp SHALL hold stable until rvalid&rready; arready returns high the cycle after.
REQ-024 Read and write paths SHALL be independent; a read handshake coinciding with the commit edge of a write to the same register returns the pre-write value.
REQ-025 Back-to-back: with bready and rready tied high, the block SHALL sustain one write every 2 cycles and one read every 2 cycles.

Reset
REQ-026 While rst_n=0 at a rising edge: awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=0, rdata=0, reg_wr_pulse=0, registers 1..N-1 = 0, holding flags cleared.
REQ-027 First cycle after rst_n=1: awready=wready=arready=1.
REQ-028 Reset asserted mid-transaction SHALL abort it: no commit, no response, pending handshakes discarded.

Verification
REQ-029 AW addr 0x04 and W data 0xDEADBEEF strb 0xF same cycle -> bvalid next cycle, bresp=00, reg_wr_pulse[1] one cycle, reg_out[63:32]=0xDEADBEEF.
REQ-030 W (data 0x11223344, strb 0x5) three cycles before AW addr 0x08, register 2 initially 0 -> register 2 = 0x00220044, bresp=00, wready low while data held.
REQ-031 Read addr 0x00 -> rdata=0xA5A50001, rresp=00; write addr 0x00 -> bresp=10, register 0 unchanged.
REQ-032 Read/write addr 0x40 (G_NB_REGS=16) -> rresp=10 rdata=0; bresp=10, no reg_wr_pulse, reg_out unchanged.
REQ-033 bready held low 5 cycles -> bvalid/bresp stable, awready=wready=0 throughout; rready low likewise holds rdata stable and arready=0.
REQ-034 rst_n low for one cycle after AW accepted but before W -> no commit after reset; subsequent W alone produces no bvalid.

Source files
------------

// File: rtl/axi4lite_slave_regfile_if.sv
// AXI4-Lite bus bundle for the register file: AW, W, B, AR and R channels.
// master drives valids/addr/data/strobes and B/R readies; slave drives the rest.
interface axi4lite_slave_regfile_if #(
  parameter int ADDR_W = 32
);
  logic              awvalid;
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awready;
  logic              wvalid;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wready;
  logic              bvalid;
  logic [1:0]        bresp;
  logic              bready;
  logic              arvalid;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arready;
  logic              rvalid;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rready;

  modport master (
    output awvalid, awaddr, awprot,
    output wvalid, wdata, wstrb,
    output bready,
    output arvalid, araddr, arprot,
    output rready,
    input  awready, wready,
    input  bvalid, bresp,
    input  arready,
    input  rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot,
    input  wvalid, wdata, wstrb,
    input  bready,
    input  arvalid, araddr, arprot,
    input  rready,
    output awready, wready,
    output bvalid, bresp,
    output arready,
    output rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4lite_slave_regfile.sv
// AXI4-Lite register file: reg 0 is a read-only ID, regs 1..N-1 are R/W.
// Ports: clk, rst_n (sync, active-low), bus (slave), reg_out, reg_wr_pulse.
module axi4lite_slave_regfile #(
  parameter int          G_AXI4_LITE_ADDR_WIDTH = 32,
  parameter int          G_AXI4_LITE_DATA_WIDTH = 32,
  parameter int          G_NB_REGS              = 16,
  parameter logic [31:0] G_REG0_ID              = 32'hA5A5_0001
) (
  input  logic                   clk,
  input  logic                   rst_n,
  axi4lite_slave_regfile_if.slave bus,
  output logic [G_NB_REGS*32-1:0] reg_out,
  output logic [G_NB_REGS-1:0]    reg_wr_pulse
);

  localparam int AW = G_AXI4_LITE_ADDR_WIDTH;
  localparam int DW = G_AXI4_LITE_DATA_WIDTH;
  localparam int IW = $clog2(G_NB_REGS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [IW-1:0] f_idx(
    input logic [AW-1:0] a
  );
    return a[IW+1:2];
  endfunction

  function automatic logic f_oor(
    input logic [AW-1:0] a
  );
    return |a[AW-1:IW+2];
  endfunction

  logic          rdy_q, rdy_d;
  logic          aw_held_q, aw_held_d;
  logic [AW-1:0] aw_addr_q, aw_addr_d;
  logic          w_held_q, w_held_d;
  logic [DW-1:0] w_data_q, w_data_d;
  logic [3:0]    w_strb_q, w_strb_d;
  logic          bvalid_q, bvalid_d;
  logic [1:0]    bresp_q, bresp_d;
  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [1:0]    rresp_q, rresp_d;
  logic [G_NB_REGS-1:0] pulse_q, pulse_d;
  logic [31:0]   regs_q [G_NB_REGS];
  logic [31:0]   regs_d [G_NB_REGS];

  logic          awready, wready, arready;
  logic          aw_hs, w_hs, ar_hs;
  logic          commit, wr_ok;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [3:0]    wr_strb;
  logic [IW-1:0] wr_idx, rd_idx;

  // rdy_q keeps every ready low during and at the edge of reset.
  assign awready = rdy_q && !aw_held_q && !bvalid_q;
  assign wready  = rdy_q && !w_held_q && !bvalid_q;
  assign arready = rdy_q && !rvalid_q;

  assign aw_hs = bus.awvalid && awready;
  assign w_hs  = bus.wvalid && wready;
  assign ar_hs = bus.arvalid && arready;

  // A held item pairs with one arriving this cycle, so a write commits
  // on the edge where its second half is accepted.
  assign wr_addr = aw_held_q ? aw_addr_q : bus.awaddr;
  assign wr_data = w_held_q ? w_data_q : bus.wdata;
  assign wr_strb = w_held_q ? w_strb_q : bus.wstrb;
  assign commit  = (aw_hs || aw_held_q) && (w_hs || w_held_q);
  assign wr_idx  = f_idx(wr_addr);
  assign wr_ok   = !f_oor(wr_addr) && (wr_idx != '0);
  assign rd_idx  = f_idx(bus.araddr);

  always_comb begin
    rdy_d     = 1'b1;
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    pulse_d   = '0;
    regs_d    = regs_q;
    regs_d[0] = G_REG0_ID;

    if (bvalid_q && bus.bready) begin
      bvalid_d = 1'b0;
    end

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
      if (wr_ok) begin
        for (int k = 0; k < 4; k++) begin
          if (wr_strb[k]) begin
            regs_d[wr_idx][8*k +: 8] = wr_data[8*k +: 8];
          end
        end
        pulse_d[wr_idx] = 1'b1;
      end
    end else begin
      if (aw_hs) begin
        aw_held_d = 1'b1;
        aw_addr_d = bus.awaddr;
      end
      if (w_hs) begin
        w_held_d = 1'b1;
        w_data_d = bus.wdata;
        w_strb_d = bus.wstrb;
      end
    end
  end

  // Reads sample regs_q, so a read coinciding with a commit sees old data.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      if (f_oor(bus.araddr)) begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
      end else begin
        rdata_d = regs_q[rd_idx];
        rresp_d = RESP_OKAY;
      end
    end else if (rvalid_q && bus.rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdy_q     <= 1'b0;
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      pulse_q   <= '0;
      regs_q[0] <= G_REG0_ID;
      for (int i = 1; i < G_NB_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      rdy_q     <= rdy_d;
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      pulse_q   <= pulse_d;
      regs_q    <= regs_d;
    end
  end

  assign bus.awready = awready;
  assign bus.wready  = wready;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.arready = arready;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;

  assign reg_wr_pulse = pulse_q;

  for (genvar i = 0; i < G_NB_REGS; i++) begin : g_out
    assign reg_out[32*i +: 32] = regs_q[i];
  end

  // Protection bits and byte-offset address bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{bus.awprot, bus.arprot,
                         bus.awaddr[1:0], bus.araddr[1:0],
                         aw_addr_q[1:0]};

endmodule

// File: tb/tb_axi4lite_slave_regfile.sv
// Directed bench for axi4lite_slave_regfile: vector table plus
// hand sequences for ordering, backpressure, throughput and reset abort.
module tb_axi4lite_slave_regfile;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [511:0] reg_out;
  logic [15:0]  reg_wr_pulse;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi4lite_slave_regfile_if #(.ADDR_W(32)) bus ();

  axi4lite_slave_regfile dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .reg_out      (reg_out),
    .reg_wr_pulse (reg_wr_pulse)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    int          idx;
    logic [1:0]  resp;
    logic [15:0] pulse;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name,
                     input logic [511:0] act,
                     input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.awvalid = 0; bus.awaddr = 0; bus.awprot = 0;
    bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0;
    bus.bready = 0;
    bus.arvalid = 0; bus.araddr = 0; bus.arprot = 0;
    bus.rready = 0;
  endtask

  task automatic do_reset();
    idle_bus();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic do_write(input logic [31:0] addr,
                          input logic [31:0] data,
                          input logic [3:0] strb,
                          input int aw_dly, input int w_dly,
                          input int bdly, input int idx,
                          input logic [1:0] resp,
                          input logic [15:0] pulse,
                          input logic [31:0] exp);
    logic aw_done, w_done, aw_go, w_go;
    logic [511:0] snap;
    snap = reg_out;
    aw_done = 0;
    w_done = 0;
    bus.awaddr = addr;
    bus.wdata = data;
    bus.wstrb = strb;
    for (int t = 0; t < 30 && !(aw_done && w_done); t++) begin
      bus.awvalid = !aw_done && (t >= aw_dly);
      bus.wvalid = !w_done && (t >= w_dly);
      if (w_done && !aw_done)
        chk("wready_while_held", bus.wready, 1'b0);
      if (aw_done && !w_done)
        chk("awready_while_held", bus.awready, 1'b0);
      aw_go = bus.awvalid && bus.awready;
      w_go = bus.wvalid && bus.wready;
      tick();
      aw_done |= aw_go;
      w_done |= w_go;
    end
    bus.awvalid = 0;
    bus.wvalid = 0;
    chk("aw_w_accepted", {aw_done, w_done}, 2'b11);
    chk("bvalid", bus.bvalid, 1'b1);
    chk("bresp", bus.bresp, resp);
    chk("wr_pulse", reg_wr_pulse, pulse);
    if (resp == 2'b00)
      chk("reg_after_write", reg_out[32*idx +: 32], exp);
    else
      chk("reg_out_unchanged", reg_out, snap);
    for (int k = 0; k < bdly; k++) begin
      tick();
      chk("b_hold",
          {bus.bvalid, bus.bresp, bus.awready, bus.wready},
          {1'b1, resp, 2'b00});
    end
    bus.bready = 1;
    tick();
    bus.bready = 0;
    chk("b_done", {bus.bvalid, reg_wr_pulse}, 17'd0);
  endtask

  task automatic do_read(input logic [31:0] addr,
                         input logic [31:0] exp,
                         input logic [1:0] resp,
                         input int rdly);
    logic done, go;
    done = 0;
    bus.araddr = addr;
    bus.arvalid = 1;
    for (int t = 0; t < 20 && !done; t++) begin
      go = bus.arvalid && bus.arready;
      tick();
      done |= go;
    end
    bus.arvalid = 0;
    chk("ar_accepted", done, 1'b1);
    chk("r_beat", {bus.rvalid, bus.rresp, bus.rdata},
        {1'b1, resp, exp});
    for (int k = 0; k < rdly; k++) begin
      tick();
      chk("r_hold",
          {bus.rvalid, bus.rresp, bus.rdata, bus.arready},
          {1'b1, resp, exp, 1'b0});
    end
    bus.rready = 1;
    tick();
    bus.rready = 0;
    chk("r_done", {bus.rvalid, bus.arready}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n_aw, n_w, n_ar;
    vecs[0]  = '{1, 32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 1, 2'b00, 16'h0002, 32'hDEADBEEF};
    vecs[1]  = '{0, 32'h04, 0, 0, 0, 0, 1, 2'b00, 0, 32'hDEADBEEF};
    vecs[2]  = '{0, 32'h00, 0, 0, 0, 0, 0, 2'b00, 0, 32'hA5A50001};
    vecs[3]  = '{1, 32'h00, 32'h12345678, 4'hF, 2, 0, 0, 2'b10, 0, 0};
    vecs[4]  = '{0, 32'h00, 0, 0, 0, 0, 0, 2'b00, 0, 32'hA5A50001};
    vecs[5]  = '{1, 32'h40, 32'hCAFEF00D, 4'hF, 0, 1, 0, 2'b10, 0, 0};
    vecs[6]  = '{0, 32'h40, 0, 0, 0, 0, 0, 2'b10, 0, 32'h0};
    vecs[7]  = '{1, 32'h3C, 32'hAABBCCDD, 4'h3, 1, 0, 15, 2'b00, 16'h8000, 32'h0000CCDD};
    vecs[8]  = '{0, 32'h3F, 0, 0, 0, 0, 15, 2'b00, 0, 32'h0000CCDD};
    vecs[9]  = '{1, 32'h05, 32'h77000000, 4'h8, 0, 0, 1, 2'b00, 16'h0002, 32'h77ADBEEF};
    vecs[10] = '{0, 32'h04, 0, 0, 0, 0, 1, 2'b00, 0, 32'h77ADBEEF};
    vecs[11] = '{0, 32'h10000004, 0, 0, 0, 0, 0, 2'b10, 0, 32'h0};
    vecs[12] = '{0, 32'h08, 0, 0, 0, 0, 2, 2'b00, 0, 32'h00220044};

    idle_bus();
    rst_n = 0;
    tick();
    tick();
    chk("rst_ready_valid",
        {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid},
        5'd0);
    chk("rst_resp_data", {bus.bresp, bus.rresp, bus.rdata}, 36'd0);
    chk("rst_pulse", reg_wr_pulse, 16'd0);
    chk("rst_regs", reg_out[511:32], 480'd0);
    chk("rst_reg0", reg_out[31:0], 32'hA5A50001);
    rst_n = 1;
    tick();
    chk("post_rst_ready",
        {bus.awready, bus.wready, bus.arready}, 3'b111);

    // W three cycles ahead of AW, partial strobe
    do_write(32'h08, 32'h11223344, 4'h5, 3, 0, 0,
             2, 2'b00, 16'h0004, 32'h00220044);

    foreach (vecs[i]) begin
      if (vecs[i].wr)
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb,
                 vecs[i].aw_dly, vecs[i].w_dly, 0, vecs[i].idx,
                 vecs[i].resp, vecs[i].pulse, vecs[i].exp);
      else
        do_read(vecs[i].addr, vecs[i].exp, vecs[i].resp, 0);
    end

    // Read and write of reg 3 on the same edge: read sees old value
    bus.awaddr = 32'h0C; bus.wdata = 32'h55; bus.wstrb = 4'hF;
    bus.araddr = 32'h0C;
    bus.awvalid = 1; bus.wvalid = 1; bus.arvalid = 1;
    chk("same_edge_ready",
        {bus.awready, bus.wready, bus.arready}, 3'b111);
    tick();
    idle_bus();
    chk("same_edge_read",
        {bus.rvalid, bus.rresp, bus.rdata}, {1'b1, 2'b00, 32'h0});
    chk("same_edge_write",
        {bus.bvalid, bus.bresp, reg_out[127:96]},
        {1'b1, 2'b00, 32'h55});
    bus.bready = 1; bus.rready = 1;
    tick();
    idle_bus();

    // Backpressure on B and R
    do_write(32'h0C, 32'h0000AA00, 4'h2, 0, 0, 5,
             3, 2'b00, 16'h0008, 32'h0000AA55);
    do_read(32'h0C, 32'h0000AA55, 2'b00, 5);
    do_read(32'h44, 32'h0, 2'b10, 3);

    // Throughput with bready/rready tied high
    n_aw = 0; n_w = 0; n_ar = 0;
    bus.awaddr = 32'h10; bus.wdata = 32'h1; bus.wstrb = 4'hF;
    bus.araddr = 32'h10;
    bus.awvalid = 1; bus.wvalid = 1; bus.arvalid = 1;
    bus.bready = 1; bus.rready = 1;
    for (int c = 0; c < 8; c++) begin
      if (bus.awvalid && bus.awready) n_aw++;
      if (bus.wvalid && bus.wready) n_w++;
      if (bus.arvalid && bus.arready) n_ar++;
      tick();
    end
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
    tick();
    tick();
    idle_bus();
    chk("thru_aw", n_aw, 4);
    chk("thru_w", n_w, 4);
    chk("thru_ar", n_ar, 4);
    chk("thru_reg4", reg_out[159:128], 32'h1);

    // Reset between AW and W aborts the write
    bus.awaddr = 32'h14; bus.awvalid = 1;
    chk("abort_awready", bus.awready, 1'b1);
    tick();
    bus.awvalid = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    bus.wdata = 32'hFFFFFFFF; bus.wstrb = 4'hF; bus.wvalid = 1;
    for (int c = 0; c < 8; c++) begin
      logic go;
      go = bus.wvalid && bus.wready;
      tick();
      if (go) bus.wvalid = 0;
      chk("abort_no_b", {bus.bvalid, reg_wr_pulse}, 17'd0);
    end
    chk("abort_w_taken", bus.wvalid, 1'b0);
    chk("abort_regs", reg_out[511:32], 480'd0);
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
